// File: rtl/npu_strm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : npu_strm_pkg
//  Brief    : Shared types and constants for the NPU argmax pair streamer.
//  Revision : 1.0 - initial release
// ============================================================================
package npu_strm_pkg;

    localparam int DW_DEF = 16;
    localparam int AW_DEF = 8;

    // Buffer read port returns data one cycle after the strobe
    localparam int RD_LAT = 1;

    // Most negative 16-bit value: padding can never win a strict compare
    localparam logic signed [15:0] PAD_VAL = 16'sh8000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        RD_A  = 3'd2,
        RD_B  = 3'd3,
        CAP_B = 3'd4,
        EMIT  = 3'd5,
        DONE  = 3'd6
    } strm_state_t;

endpackage
`default_nettype wire

// File: rtl/npu_pair_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : npu_pair_streamer
//  Brief    : Reads N signed results from the output buffer and streams them
//             as (out1,out2) pairs with a trig strobe to the argmax unit.
//  Revision : 1.0 - initial release
// ============================================================================
module npu_pair_streamer
    import npu_strm_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic                 CLKEXT,
    input  logic                 RST_STRM,
    input  logic                 EN_STRM,
    input  logic                 start,
    input  logic [AW-1:0]        count,
    output logic                 rd_en,
    output logic [AW-1:0]        rd_addr,
    input  logic signed [DW-1:0] rd_data,
    output logic                 comp_clr,
    output logic                 trig,
    output logic signed [DW-1:0] out1,
    output logic signed [DW-1:0] out2,
    output logic                 busy,
    output logic                 done
);

    // Generic most-negative value so the padding rule holds for any DW
    localparam logic signed [DW-1:0] c_pad = {1'b1, {(DW-1){1'b0}}};

    strm_state_t          r_state;
    strm_state_t          w_next;
    logic [AW-1:0]        r_count;
    logic [AW:0]          r_ptr;
    logic signed [DW-1:0] r_out1;
    logic signed [DW-1:0] r_out2;
    logic                 r_busy;

    logic [AW:0]          w_n;
    logic [AW:0]          w_ptr1;
    logic [AW:0]          w_ptr2;
    logic                 w_has_b;

    // Pointer is one bit wider than the count so ptr+2 cannot wrap at N=2^AW-1
    assign w_n     = {1'b0, r_count};
    assign w_ptr1  = r_ptr + (AW+1)'(1);
    assign w_ptr2  = r_ptr + (AW+1)'(2);
    assign w_has_b = (w_ptr1 < w_n);

    always_comb begin
        w_next   = r_state;
        rd_en    = 1'b0;
        rd_addr  = '0;
        comp_clr = 1'b0;
        trig     = 1'b0;
        done     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && EN_STRM) w_next = CLR;
            end
            CLR: begin
                comp_clr = 1'b1;
                w_next   = (r_count == '0) ? DONE : RD_A;
            end
            RD_A: begin
                if (EN_STRM) begin
                    rd_en   = 1'b1;
                    rd_addr = r_ptr[AW-1:0];
                    w_next  = RD_B;
                end
            end
            RD_B: begin
                if (w_has_b) begin
                    rd_en   = 1'b1;
                    rd_addr = w_ptr1[AW-1:0];
                end
                w_next = CAP_B;
            end
            CAP_B: begin
                w_next = EMIT;
            end
            EMIT: begin
                if (EN_STRM) begin
                    trig   = 1'b1;
                    w_next = (w_ptr2 >= w_n) ? DONE : RD_A;
                end
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLKEXT or posedge RST_STRM) begin
        if (RST_STRM) begin
            r_state <= IDLE;
            r_count <= '0;
            r_ptr   <= '0;
            r_out1  <= '0;
            r_out2  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != IDLE);
            case (r_state)
                IDLE: begin
                    if (start && EN_STRM) begin
                        r_count <= count;
                        r_ptr   <= '0;
                    end
                end
                RD_B: begin
                    r_out1 <= rd_data;
                end
                CAP_B: begin
                    // Same condition that decided the second read in RD_B
                    r_out2 <= w_has_b ? rd_data : c_pad;
                end
                EMIT: begin
                    if (EN_STRM) r_ptr <= w_ptr2;
                end
                default: begin
                end
            endcase
        end
    end

    assign out1 = r_out1;
    assign out2 = r_out2;
    assign busy = r_busy;

endmodule
`default_nettype wire
